// File: rtl/input_mapper.sv
// Player-input front end: decodes PS/2 key events into held-key state per player,
// ORs it with HPS joystick words, and produces registered directions/buttons plus coin pulses and pause toggles.
module input_mapper #(
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned BUTTONS     = 3,
  parameter logic [23:0] COIN_CYCLES = 24'd1000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [32*PLAYERS-1:0]        joystick,
  output logic [PLAYERS-1:0]           up,
  output logic [PLAYERS-1:0]           down,
  output logic [PLAYERS-1:0]           left,
  output logic [PLAYERS-1:0]           right,
  output logic [BUTTONS*PLAYERS-1:0]   buttons,
  output logic [PLAYERS-1:0]           start,
  output logic [PLAYERS-1:0]           service,
  output logic [PLAYERS-1:0]           coin,
  output logic [PLAYERS-1:0]           pause
);

  localparam int unsigned NB      = 8 + BUTTONS;
  localparam int unsigned B_START = 4 + BUTTONS;
  localparam int unsigned B_COIN  = 5 + BUTTONS;
  localparam int unsigned B_PAUSE = 6 + BUTTONS;
  localparam int unsigned B_SERV  = 7 + BUTTONS;

  logic              prev_tog;
  logic              key_event;
  logic              key_known;
  logic              key_is_btn;
  logic              key_hit;
  int unsigned       key_pl;
  int unsigned       key_btn;
  int unsigned       key_bit;
  int unsigned       fixed_bit;

  logic [NB-1:0]     kbd      [PLAYERS];
  logic [NB-1:0]     raw      [PLAYERS];
  logic [NB-1:0]     raw_prev [PLAYERS];
  logic [23:0]       cnt      [PLAYERS];
  logic [PLAYERS-1:0] pause_st;
  logic              unused_bits;

  assign key_event   = ps2_key[10] != prev_tog;
  assign unused_bits = ^joystick;

  // Arrow codes need the E0 prefix; every other code ignores it so right Ctrl/Alt alias left.
  always_comb begin
    key_known  = 1'b1;
    key_is_btn = 1'b0;
    key_pl     = 0;
    key_btn    = 0;
    fixed_bit  = 0;
    case (ps2_key[7:0])
      8'h75: begin fixed_bit = 3; key_known = ps2_key[8]; end
      8'h72: begin fixed_bit = 2; key_known = ps2_key[8]; end
      8'h6B: begin fixed_bit = 1; key_known = ps2_key[8]; end
      8'h74: begin fixed_bit = 0; key_known = ps2_key[8]; end
      8'h14: begin key_is_btn = 1'b1; key_btn = 0; end
      8'h11: begin key_is_btn = 1'b1; key_btn = 1; end
      8'h29: begin key_is_btn = 1'b1; key_btn = 2; end
      8'h12: begin key_is_btn = 1'b1; key_btn = 3; end
      8'h1A: begin key_is_btn = 1'b1; key_btn = 4; end
      8'h22: begin key_is_btn = 1'b1; key_btn = 5; end
      8'h16: fixed_bit = B_START;
      8'h2E: fixed_bit = B_COIN;
      8'h4D: fixed_bit = B_PAUSE;
      8'h46: fixed_bit = B_SERV;
      8'h2D: begin key_pl = 1; fixed_bit = 3; end
      8'h2B: begin key_pl = 1; fixed_bit = 2; end
      8'h23: begin key_pl = 1; fixed_bit = 1; end
      8'h34: begin key_pl = 1; fixed_bit = 0; end
      8'h1C: begin key_pl = 1; key_is_btn = 1'b1; key_btn = 0; end
      8'h1B: begin key_pl = 1; key_is_btn = 1'b1; key_btn = 1; end
      8'h15: begin key_pl = 1; key_is_btn = 1'b1; key_btn = 2; end
      8'h1E: begin key_pl = 1; fixed_bit = B_START; end
      8'h36: begin key_pl = 1; fixed_bit = B_COIN; end
      8'h45: begin key_pl = 1; fixed_bit = B_SERV; end
      default: key_known = 1'b0;
    endcase
    key_bit = key_is_btn ? 4 + key_btn : fixed_bit;
    key_hit = key_event && key_known && (key_pl < PLAYERS) && (!key_is_btn || key_btn < BUTTONS);
  end

  always_comb begin
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      raw[p] = kbd[p] | joystick[32*p +: NB];
    end
  end

  always_ff @(posedge clock) begin
    prev_tog <= ps2_key[10];
    if (reset) begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        kbd[p]      <= '0;
        raw_prev[p] <= raw[p];
        cnt[p]      <= '0;
      end
      pause_st <= '0;
      up       <= '0;
      down     <= '0;
      left     <= '0;
      right    <= '0;
      buttons  <= '0;
      start    <= '0;
      service  <= '0;
      coin     <= '0;
      pause    <= '0;
    end else begin
      for (int unsigned p = 0; p < PLAYERS; p++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (key_hit && key_pl == p && key_bit == b) kbd[p][b] <= ps2_key[9];
        end
        raw_prev[p] <= raw[p];
        // Edges arriving while a pulse is running are dropped, so a held coin gives one pulse.
        if (raw[p][B_COIN] && !raw_prev[p][B_COIN] && cnt[p] == '0) cnt[p] <= COIN_CYCLES;
        else if (cnt[p] != '0) cnt[p] <= cnt[p] - 24'd1;
        if (raw[p][B_PAUSE] && !raw_prev[p][B_PAUSE]) pause_st[p] <= ~pause_st[p];
        right[p]   <= raw[p][0];
        left[p]    <= raw[p][1];
        down[p]    <= raw[p][2];
        up[p]      <= raw[p][3];
        buttons[BUTTONS*p +: BUTTONS] <= raw[p][4 +: BUTTONS];
        start[p]   <= raw[p][B_START];
        service[p] <= raw[p][B_SERV];
        coin[p]    <= cnt[p] != '0;
        pause[p]   <= pause_st[p];
      end
    end
  end

endmodule
